// File: rtl/toast_cycle_timer.sv
// ============================================================================
// toast_cycle_timer
// ----------------------------------------------------------------------------
// Purpose
//   Responder end of the keypad-control write/write_ack handshake. It latches
//   the cook time (seconds) and the heater duty (percent), runs the toast cycle
//   under start/stop control, drives the heater PWM and the relay mode line,
//   and reports the seconds left for the 7-segment display path. It runs on a
//   single clock domain.
//
// Optional feature
//   TOAST_PREHEAT_EN : when defined, the first PREHEAT_S seconds of a cycle that
//                      starts from IDLE/DONE run the heater full-on, whatever
//                      the duty. When undefined, pwm follows the duty for the
//                      whole cycle and PREHEAT_S is unused.
//
// Parameters
//   CLK_HZ     clk cycles per one-second tick
//   PWM_STEPS  PWM period in clk cycles (one duty unit = one step)
//   PREHEAT_S  preheat length in seconds (TOAST_PREHEAT_EN only)
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   write        in   1   write request, held high until write_ack is seen
//   Time         in  10   requested cook time, seconds
//   DC           in   8   requested duty, percent (values above 100 clamp)
//   write_ack    out  1   one-cycle acknowledge of an accepted write
//   start        in   1   start/resume request (level)
//   stop         in   1   pause/cancel request (level)
//   pwm          out  1   heater PWM
//   mode         out  1   high while running (heater relay enable)
//   remaining    out 10   seconds left in the current cycle
//   done         out  1   one-cycle pulse when the cycle completes
//   state_dbg_o  out  2   FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//
// Handshake
//   The initiator raises write with Time/DC valid and holds all three until it
//   sees write_ack. A write is taken on the first edge where write is high, was
//   low on the previous edge and write_ack is low; write_ack is high for exactly
//   the following cycle. A write that stays high after its ack is not taken a
//   second time; it has to drop for at least one cycle first.
// ============================================================================
module toast_cycle_timer #(
    parameter int CLK_HZ    = 2000,
    parameter int PWM_STEPS = 100,
    parameter int PREHEAT_S = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write,
    input  logic [9:0] Time,
    input  logic [7:0] DC,
    output logic       write_ack,
    input  logic       start,
    input  logic       stop,
    output logic       pwm,
    output logic       mode,
    output logic [9:0] remaining,
    output logic       done,
    output logic [1:0] state_dbg_o
);

    localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int PWM_W = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
    localparam int CMP_W = (PWM_W > 8) ? PWM_W : 8;

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
    localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [9:0]       t_set_q,     t_set_d;
    logic [7:0]       dc_set_q,    dc_set_d;
    logic [7:0]       duty_q,      duty_d;      // duty frozen for the current PWM period
    logic [9:0]       remaining_q, remaining_d;
    logic [SEC_W-1:0] sec_cnt_q,   sec_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q,   pwm_cnt_d;
    logic             write_q;
    logic             stop_q;
    logic             write_ack_q, write_ack_d;
    logic             done_q,      done_d;
    logic             pwm_q,       pwm_d;
    logic             mode_q,      mode_d;

    // ------------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------------
    logic       accept;
    logic       stop_rise;
    logic       sec_tick;
    logic [7:0] dc_clamped;

    assign accept     = write & ~write_q & ~write_ack_q;
    // Cancel from PAUSE needs a fresh stop, so the stop that paused (possibly
    // still held) does not also throw the cycle away.
    assign stop_rise  = stop & ~stop_q;
    assign sec_tick   = (sec_cnt_q == SEC_LAST);
    assign dc_clamped = (DC > 8'd100) ? 8'd100 : DC;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [CMP_W-1:0] cnt_cmp;
    logic [CMP_W-1:0] duty_cmp;
    logic             preheat_d;

    always_comb begin
        state_d     = state_q;
        t_set_d     = t_set_q;
        dc_set_d    = dc_set_q;
        remaining_d = remaining_q;
        sec_cnt_d   = sec_cnt_q;
        write_ack_d = accept;
        done_d      = 1'b0;

        // Duty can change in every state; it only reaches the heater at the
        // next PWM period boundary through duty_q.
        if (accept) begin
            dc_set_d = dc_clamped;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    t_set_d     = Time;
                    remaining_d = Time;
                end else if (!stop && start && (remaining_q != '0)) begin
                    state_d   = ST_RUN;
                    sec_cnt_d = '0;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // sec_cnt is held so a resume finishes the partial second.
                    state_d = ST_PAUSE;
                end else if (sec_tick) begin
                    sec_cnt_d = '0;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - 10'd1;
                        if (remaining_q == 10'd1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    sec_cnt_d = sec_cnt_q + SEC_W'(1);
                end
            end

            ST_PAUSE: begin
                if (stop_rise) begin
                    state_d     = ST_IDLE;
                    remaining_d = t_set_q;
                    sec_cnt_d   = '0;
                end else if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (accept) begin
                    t_set_d     = Time;
                    remaining_d = Time;
                end
                if (stop || accept) begin
                    state_d = ST_IDLE;
                end else if (start && (t_set_q != '0)) begin
                    state_d     = ST_RUN;
                    remaining_d = t_set_q;
                    sec_cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // PWM counter runs only while staying in RUN; any entry into RUN
        // starts a fresh period.
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
        end else begin
            pwm_cnt_d = '0;
        end

        // Duty is sampled at the start of each period and held for its length.
        duty_d = (pwm_cnt_d == '0) ? dc_set_d : duty_q;

`ifdef TOAST_PREHEAT_EN
        // Full-on while the cycle is still within its first PREHEAT_S seconds,
        // i.e. remaining > t_set - PREHEAT_S (written without subtraction so a
        // short t_set cannot wrap).
        preheat_d = ({2'b00, remaining_d} + 12'(PREHEAT_S)) > {2'b00, t_set_d};
`else
        preheat_d = 1'b0;
`endif

        cnt_cmp  = CMP_W'(pwm_cnt_d);
        duty_cmp = CMP_W'(duty_d);

        // Outputs are registered from next-state values, so they change in the
        // same cycle as the state they describe.
        mode_d = (state_d == ST_RUN);
        pwm_d  = (state_d == ST_RUN) && (preheat_d || (cnt_cmp < duty_cmp));
    end

`ifndef TOAST_PREHEAT_EN
    logic [31:0] unused_preheat;
    assign unused_preheat = 32'(PREHEAT_S);
`endif

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            t_set_q     <= '0;
            dc_set_q    <= '0;
            duty_q      <= '0;
            remaining_q <= '0;
            sec_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            write_q     <= 1'b0;
            stop_q      <= 1'b0;
            write_ack_q <= 1'b0;
            done_q      <= 1'b0;
            pwm_q       <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_set_q     <= t_set_d;
            dc_set_q    <= dc_set_d;
            duty_q      <= duty_d;
            remaining_q <= remaining_d;
            sec_cnt_q   <= sec_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            write_q     <= write;
            stop_q      <= stop;
            write_ack_q <= write_ack_d;
            done_q      <= done_d;
            pwm_q       <= pwm_d;
            mode_q      <= mode_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign write_ack   = write_ack_q;
    assign pwm         = pwm_q;
    assign mode        = mode_q;
    assign remaining   = remaining_q;
    assign done        = done_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_toast_cycle_timer.sv
module tb_toast_cycle_timer;

    localparam int CLK_HZ    = 10;
    localparam int PWM_STEPS = 100;
    localparam int PREHEAT_S = 5;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

`ifdef TOAST_PREHEAT_EN
    localparam int EXP_HIGHS_T25 = 130;
    localparam int EXP_HIGHS_DC0 = 40;
`else
    localparam int EXP_HIGHS_T25 = 120;
    localparam int EXP_HIGHS_DC0 = 0;
`endif

    // ------------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------------
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       write = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [9:0] Time  = '0;
    logic [7:0] DC    = '0;
    logic       write_ack;
    logic       pwm;
    logic       mode;
    logic       done;
    logic [9:0] remaining;
    logic [1:0] state_dbg_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    toast_cycle_timer #(
        .CLK_HZ   (CLK_HZ),
        .PWM_STEPS(PWM_STEPS),
        .PREHEAT_S(PREHEAT_S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .Time       (Time),
        .DC         (DC),
        .write_ack  (write_ack),
        .start      (start),
        .stop       (stop),
        .pwm        (pwm),
        .mode       (mode),
        .remaining  (remaining),
        .done       (done),
        .state_dbg_o(state_dbg_o)
    );

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: remaining is derived from the number of RUN cycles
    // spent in this cycle, PWM from the position since the last RUN entry.
    // ------------------------------------------------------------------------
    int m_state   = S_IDLE;
    int m_tset    = 0;
    int m_base    = 0;
    int m_elapsed = 0;
    int m_dc      = 0;
    int m_pos     = 0;
    int m_pduty   = 0;
    bit m_ack, m_done, m_pwm, m_mode, m_wr_prev, m_stop_prev;
    bit model_live = 1'b0;

    function automatic int m_rem();
        return m_base - (m_elapsed / CLK_HZ);
    endfunction

    always @(posedge clk) begin : model
        int nxt;
        bit acc;
        bit srise;
        bit pre;
        model_live = 1'b1;
        if (reset) begin
            m_state = S_IDLE; m_tset = 0; m_base = 0; m_elapsed = 0;
            m_dc = 0; m_pos = 0; m_pduty = 0;
            m_ack = 0; m_done = 0; m_pwm = 0; m_mode = 0;
            m_wr_prev = 0; m_stop_prev = 0;
        end else begin
            acc   = write && !m_wr_prev && !m_ack;
            srise = stop && !m_stop_prev;
            nxt   = m_state;
            m_done = 0;
            if (acc) m_dc = (DC > 8'd100) ? 100 : int'(DC);
            case (m_state)
                S_IDLE: begin
                    if (acc) begin
                        m_tset = int'(Time); m_base = int'(Time); m_elapsed = 0;
                    end else if (!stop && start && m_rem() != 0) begin
                        nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) nxt = S_PAUSE;
                    else begin
                        m_elapsed++;
                        if (m_rem() == 0) begin
                            nxt = S_DONE;
                            m_done = 1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (srise) begin
                        nxt = S_IDLE; m_base = m_tset; m_elapsed = 0;
                    end else if (start && !stop) begin
                        nxt = S_RUN;
                    end
                end
                default: begin
                    if (acc) begin
                        m_tset = int'(Time); m_base = int'(Time); m_elapsed = 0;
                        nxt = S_IDLE;
                    end else if (stop) begin
                        nxt = S_IDLE;
                    end else if (start && m_tset != 0) begin
                        nxt = S_RUN; m_base = m_tset; m_elapsed = 0;
                    end
                end
            endcase
            if (nxt == S_RUN) begin
                m_pos = (m_state == S_RUN) ? m_pos + 1 : 0;
                if (m_pos % PWM_STEPS == 0) m_pduty = m_dc;
            end
`ifdef TOAST_PREHEAT_EN
            pre = m_rem() > (m_tset - PREHEAT_S);
`else
            pre = 0;
`endif
            m_pwm       = (nxt == S_RUN) && (pre || (m_pos % PWM_STEPS) < m_pduty);
            m_mode      = (nxt == S_RUN);
            m_ack       = acc;
            m_state     = nxt;
            m_wr_prev   = write;
            m_stop_prev = stop;
        end
    end

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("cmp_write_ack", int'(write_ack), int'(m_ack));
            check("cmp_done", int'(done), int'(m_done));
            check("cmp_pwm", int'(pwm), int'(m_pwm));
            check("cmp_mode", int'(mode), int'(m_mode));
            check("cmp_remaining", int'(remaining), m_rem());
            check("cmp_state", int'(state_dbg_o), m_state);
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks (inputs change only just after a falling edge)
    // ------------------------------------------------------------------------
    task automatic do_write(input int t, input int dc, input int hold);
        @(negedge clk);
        write = 1'b1;
        Time  = 10'(t);
        DC    = 8'(dc);
        @(negedge clk);
        check("ack_latency", int'(write_ack), 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ack_not_repeated", int'(write_ack), 0);
        end
        write = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_until_done(input int max_cyc, output int highs);
        bit seen;
        seen  = 0;
        highs = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (pwm) highs++;
            @(negedge clk);
        end
        check("done_seen", int'(seen), 1);
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin : stim
        int highs;
        int n_done;

        repeat (3) @(negedge clk);
        check("rst_write_ack", int'(write_ack), 0);
        check("rst_pwm", int'(pwm), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_done", int'(done), 0);
        check("rst_state", int'(state_dbg_o), S_IDLE);
        reset = 1'b0;

        // 1: write accepted once while held
        do_write(3, 40, 3);
        check("t1_remaining", int'(remaining), 3);
        check("t1_state", int'(state_dbg_o), S_IDLE);

        // 2: short run to completion, then a longer run
        pulse_start();
        check("t2_mode", int'(mode), 1);
        check("t2_remaining", int'(remaining), 3);
        run_until_done(100, highs);
        check("t2_highs", highs, 30);
        check("t2_done_mode", int'(mode), 0);
        check("t2_done_pwm", int'(pwm), 0);
        check("t2_done_state", int'(state_dbg_o), S_DONE);
        @(negedge clk);
        check("t2_done_one_cycle", int'(done), 0);

        do_write(25, 40, 0);
        check("t2b_state", int'(state_dbg_o), S_IDLE);
        check("t2b_remaining", int'(remaining), 25);
        pulse_start();
        run_until_done(300, highs);
        check("t2b_highs", highs, EXP_HIGHS_T25);

        // 3: pause, resume, cancel
        do_write(5, 40, 0);
        pulse_start();
        repeat (15) @(negedge clk);
        check("t3_rem_before_stop", int'(remaining), 4);
        stop = 1'b1;
        @(negedge clk);
        check("t3_pause_mode", int'(mode), 0);
        check("t3_pause_pwm", int'(pwm), 0);
        check("t3_pause_rem", int'(remaining), 4);
        check("t3_pause_state", int'(state_dbg_o), S_PAUSE);
        repeat (2) @(negedge clk);
        check("t3_held_stop_no_cancel", int'(state_dbg_o), S_PAUSE);
        stop = 1'b0;
        pulse_start();
        check("t3_resume_mode", int'(mode), 1);
        check("t3_resume_rem", int'(remaining), 4);
        repeat (4) @(negedge clk);
        check("t3_rem_before_tick", int'(remaining), 4);
        @(negedge clk);
        check("t3_rem_after_tick", int'(remaining), 3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t3_pause2_state", int'(state_dbg_o), S_PAUSE);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        check("t3_cancel_state", int'(state_dbg_o), S_IDLE);
        check("t3_cancel_rem", int'(remaining), 5);
        stop = 1'b0;

        // 4: duty 0, duty clamp, mid-run duty change, start&stop in IDLE
        do_write(4, 0, 0);
        pulse_start();
        run_until_done(60, highs);
        check("t4_dc0_highs", highs, EXP_HIGHS_DC0);

        do_write(15, 200, 0);
        pulse_start();
        repeat (20) @(negedge clk);
        do_write(9, 10, 0);
        check("t4_time_ignored_rem", int'(remaining), 13);
        run_until_done(200, highs);
        check("t4_clamp_then_dc10_highs", highs, 88);

        do_write(2, 50, 0);
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        check("t4_start_stop_state", int'(state_dbg_o), S_IDLE);
        check("t4_start_stop_mode", int'(mode), 0);
        start = 1'b0;
        stop  = 1'b0;

        // 5: reset mid-run
        do_write(3, 50, 0);
        pulse_start();
        repeat (12) @(negedge clk);
        check("t5_rem_before_reset", int'(remaining), 2);
        reset = 1'b1;
        @(negedge clk);
        check("t5_write_ack", int'(write_ack), 0);
        check("t5_pwm", int'(pwm), 0);
        check("t5_mode", int'(mode), 0);
        check("t5_remaining", int'(remaining), 0);
        check("t5_done", int'(done), 0);
        check("t5_state", int'(state_dbg_o), S_IDLE);
        reset  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("t5_no_done", n_done, 0);
        pulse_start();
        check("t5_start_noop_mode", int'(mode), 0);
        check("t5_start_noop_state", int'(state_dbg_o), S_IDLE);

`ifdef TOAST_PREHEAT_EN
        // 6: preheat then duty
        do_write(20, 10, 0);
        pulse_start();
        run_until_done(250, highs);
        check("t6_preheat_highs", highs, 60);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
